// File: rtl/tap_line_shifter.sv
// Tapped shift chain with a programmable active length. When the chain is full, a push evicts the
// oldest sample into a ready/valid output register; parallel taps expose any active stage.
module tap_line_shifter #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_DEPTH = 8,
    parameter int NUM_TAPS    = 3,
    parameter int LW          = $clog2(SHIFT_DEPTH + 1),
    parameter int TW          = $clog2(SHIFT_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [LW-1:0]                  cfg_len,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic [NUM_TAPS*TW-1:0]         tap_sel,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
    output logic [NUM_TAPS-1:0]            tap_valid,
    output logic [LW-1:0]                  fill_cnt
);
    localparam logic [LW-1:0] MaxLen = LW'(SHIFT_DEPTH);

    logic [DATA_WIDTH-1:0] stage_q [SHIFT_DEPTH];
    logic [DATA_WIDTH-1:0] stage_d [SHIFT_DEPTH];
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         fill_q, fill_d;
    logic [LW-1:0]         cfg_len_eff;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] last_stage;
    logic                  full, push, evict, consume;

    // Zero selects the full physical chain; oversize requests are clamped to it.
    always_comb begin
        if (cfg_len == '0 || cfg_len > MaxLen) begin
            cfg_len_eff = MaxLen;
        end else begin
            cfg_len_eff = cfg_len;
        end
    end

    assign full     = (fill_q == len_q);
    assign in_ready = !full || !out_valid_q || out_ready;
    assign push     = in_valid && in_ready;
    assign evict    = push && full;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        last_stage = '0;
        for (int i = 0; i < SHIFT_DEPTH; i++) begin
            if (LW'(i) == len_q - LW'(1)) begin
                last_stage = stage_q[i];
            end
        end
    end

    // Stages at or beyond the active length never load, so they stay at zero.
    always_comb begin
        for (int i = 0; i < SHIFT_DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (flush) begin
            for (int i = 0; i < SHIFT_DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (push) begin
            stage_d[0] = in_data;
            for (int i = 1; i < SHIFT_DEPTH; i++) begin
                if (LW'(i) < len_q) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end
    end

    always_comb begin
        len_d       = len_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            len_d       = cfg_len_eff;
            fill_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push && !full) begin
                fill_d = fill_q + LW'(1);
            end
            if (evict) begin
                out_data_d  = last_stage;
                out_valid_d = 1'b1;
            end else if (consume) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= cfg_len_eff;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < SHIFT_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            len_q       <= len_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < SHIFT_DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic [TW-1:0]         sel;
        logic [DATA_WIDTH-1:0] sel_data;

        assign sel = tap_sel[k*TW +: TW];

        always_comb begin
            sel_data = '0;
            for (int i = 0; i < SHIFT_DEPTH; i++) begin
                if (TW'(i) == sel) begin
                    sel_data = stage_q[i];
                end
            end
        end

        assign tap_data[k*DATA_WIDTH +: DATA_WIDTH] = (LW'(sel) < len_q) ? sel_data : '0;
        assign tap_valid[k] = (LW'(sel) < fill_q);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_tap_line_shifter.sv
// Bench for tap_line_shifter: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based reference model and an in-order scoreboard.
module tb_tap_line_shifter;
    localparam int DW = 16;
    localparam int SD = 8;
    localparam int NT = 3;
    localparam int LW = $clog2(SD + 1);
    localparam int TW = $clog2(SD);

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic [LW-1:0]    cfg_len;
    logic [DW-1:0]    in_data;
    logic             in_ready, out_valid;
    logic [DW-1:0]    out_data;
    logic [NT*TW-1:0] tap_sel;
    logic [NT*DW-1:0] tap_data;
    logic [NT-1:0]    tap_valid;
    logic [LW-1:0]    fill_cnt;

    always #5 clk = ~clk;

    tap_line_shifter #(
        .DATA_WIDTH (DW),
        .SHIFT_DEPTH(SD),
        .NUM_TAPS   (NT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .cfg_len  (cfg_len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .tap_sel  (tap_sel),
        .tap_data (tap_data),
        .tap_valid(tap_valid),
        .fill_cnt (fill_cnt)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    bit sb_on = 1'b0;

    // Model: m_q holds the live samples, newest at index 0.
    int            m_len = SD;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_od = '0;
    bit            m_ov = 1'b0;
    logic [DW-1:0] sent[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [LW-1:0] c);
        return (c == 0 || int'(c) > SD) ? SD : int'(c);
    endfunction

    function automatic bit m_ready();
        return (m_q.size() != m_len) || !m_ov || out_ready;
    endfunction

    // One clock: compare outputs against the model, advance the model, step past the edge.
    task automatic cycle();
        #3;
        if (checking) begin
            check("in_ready", in_ready, m_ready());
            check("fill_cnt", fill_cnt, m_q.size());
            check("out_valid", out_valid, m_ov);
            check("out_data", out_data, m_od);
            for (int k = 0; k < NT; k++) begin
                int            sel;
                logic [DW-1:0] ed;
                sel = int'(tap_sel[k*TW +: TW]);
                ed  = '0;
                if (sel < m_q.size()) ed = m_q[sel];
                check($sformatf("tap_data%0d", k), tap_data[k*DW +: DW], ed);
                check($sformatf("tap_valid%0d", k), tap_valid[k], sel < m_q.size());
            end
        end
        if (rst || flush) begin
            m_q.delete();
            m_ov  = 1'b0;
            m_len = eff_len(cfg_len);
            if (rst) m_od = '0;
        end else begin
            bit rdy;
            bit cons;
            rdy  = m_ready();
            cons = m_ov && out_ready;
            if (sb_on && cons && sent.size() > 0) check("sb_order", out_data, sent.pop_front());
            if (in_valid && rdy) begin
                if (sb_on) sent.push_back(in_data);
                m_q.push_front(in_data);
                if (m_q.size() > m_len) begin
                    m_od = m_q.pop_back();
                    m_ov = 1'b1;
                end else if (cons) begin
                    m_ov = 1'b0;
                end
            end else if (cons) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int len);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_len = LW'(len);
        cycle();
        rst = 1'b0;
    endtask

    task automatic push_val(input logic [DW-1:0] v, input logic ordy);
        in_valid = 1'b1; in_data = v; out_ready = ordy;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; cfg_len = '0; tap_sel = '0;

        // Fill and evict
        do_reset(4);
        checking = 1'b1;
        check("ready_after_rst", in_ready, 1);
        for (int i = 1; i <= 6; i++) begin
            push_val(DW'(i), 1'b1);
            check("s1_fill", fill_cnt, (i < 4) ? i : 4);
            check("s1_ov", out_valid, i >= 5);
            if (i == 5) check("s1_od5", out_data, 1);
            if (i == 6) check("s1_od6", out_data, 2);
        end

        // Backpressure
        do_reset(4);
        for (int i = 1; i <= 4; i++) push_val(DW'(i), 1'b1);
        push_val(5, 1'b0);
        check("s2_ov", out_valid, 1);
        check("s2_od", out_data, 1);
        check("s2_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 6; out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("s2_hold_ready", in_ready, 0);
            check("s2_hold_od", out_data, 1);
            check("s2_hold_tap0", tap_data[0 +: DW], 5);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("s2_od_after", out_data, 2);
        check("s2_ov_after", out_valid, 1);
        check("s2_tap0_after", tap_data[0 +: DW], 6);
        cycle();
        check("s2_drained", out_valid, 0);

        // Taps
        do_reset(8);
        tap_sel = {3'd7, 3'd3, 3'd0};
        for (int i = 1; i <= 3; i++) push_val(DW'(10 * i), 1'b1);
        check("s3_tv3", tap_valid, 3'b001);
        for (int i = 4; i <= 8; i++) push_val(DW'(10 * i), 1'b1);
        check("s3_tv8", tap_valid, 3'b111);
        check("s3_tap0", tap_data[0 +: DW], 80);
        check("s3_tap1", tap_data[DW +: DW], 50);
        check("s3_tap2", tap_data[2*DW +: DW], 10);

        // Length boundaries
        do_reset(0);
        for (int i = 1; i <= 8; i++) push_val(DW'(i), 1'b1);
        check("s4_len0_fill", fill_cnt, 8);
        check("s4_len0_noev", out_valid, 0);
        push_val(9, 1'b1);
        check("s4_len0_ev", out_data, 1);
        do_reset(1);
        push_val(16'hA, 1'b1);
        check("s4_len1_fill", fill_cnt, 1);
        check("s4_len1_noev", out_valid, 0);
        push_val(16'hB, 1'b1);
        check("s4_len1_odA", out_data, 16'hA);
        push_val(16'hC, 1'b1);
        check("s4_len1_odB", out_data, 16'hB);
        do_reset(3);
        tap_sel = {3'd0, 3'd0, 3'd5};
        for (int i = 1; i <= 3; i++) push_val(DW'(i), 1'b1);
        check("s4_sel5_data", tap_data[0 +: DW], 0);
        check("s4_sel5_valid", tap_valid[0], 0);
        check("s4_sel0_valid", tap_valid[1], 1);

        // Flush, then reset, mid-stream
        do_reset(4);
        tap_sel = {3'd2, 3'd1, 3'd0};
        for (int i = 1; i <= 5; i++) push_val(DW'(i), 1'b0);
        check("s5_full_ov", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_data = 99; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("s5_fl_fill", fill_cnt, 0);
        check("s5_fl_ov", out_valid, 0);
        check("s5_fl_taps", tap_data, 0);
        check("s5_fl_tv", tap_valid, 0);
        push_val(7, 1'b1);
        check("s5_fl_new", tap_data[0 +: DW], 7);
        check("s5_fl_drop", tap_data[DW +: DW], 0);
        for (int i = 1; i <= 5; i++) push_val(DW'(i), 1'b0);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 99; out_ready = 1'b1;
        cfg_len = 2;
        cycle();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cfg_len = 5;
        check("s5_rst_fill", fill_cnt, 0);
        check("s5_rst_ov", out_valid, 0);
        check("s5_rst_od", out_data, 0);
        push_val(1, 1'b1);
        push_val(2, 1'b1);
        check("s5_len2_fill", fill_cnt, 2);
        check("s5_len2_noev", out_valid, 0);
        push_val(3, 1'b1);
        check("s5_len2_ev", out_data, 1);
        check("s5_len2_fill2", fill_cnt, 2);

        // Randomized traffic
        for (int r = 0; r < 5; r++) begin
            do_reset(int'($urandom_range(0, SD)));
            sent.delete();
            sb_on = 1'b1;
            repeat (300) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = DW'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                tap_sel   = (NT*TW)'($urandom);
                cfg_len   = LW'($urandom_range(0, SD));
                cycle();
            end
            sb_on = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
